uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares the single UART TX FIFO push port of `uart_controller` between N_REQ byte-stream requesters, such as the sensor readout and the watch time report.
- Grants the port round-robin at packet boundaries.
- Frames each packet as: header byte (requester tag), payload, CR, LF.
- Aborts a stalled requester after a timeout so the UART link can never hang.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- HDR_BASE, 8'h41, header byte for requester i is HDR_BASE+i ('A', 'B', ...).
- TIMEOUT, 1_000_000, cycles without a valid payload byte before the packet is aborted (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- req_valid  in  N_REQ  per-requester payload byte valid.
- req_data  in  8*N_REQ  per-requester payload byte; requester i occupies bits [8i+7:8i].
- req_last  in  N_REQ  marks the final payload byte of the packet; qualified by valid.
- req_ready  out  N_REQ  payload byte accepted this cycle when valid&ready.
- tx_full  in  1  TX FIFO full flag from `uart_controller`.
- tx_push  out  1  one-cycle push strobe into the TX FIFO.
- tx_push_data  out  8  byte pushed with tx_push.
- grant  out  N_REQ  one-hot; identifies the current packet owner, all-zero in IDLE.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a packet is aborted.

Behaviour:
- States are IDLE, HDR, PAY, CR, LF.
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=0; busy=0; timeout_err=0; timeout counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - Reset mid-packet drops the packet immediately; no trailer is emitted.
- Output timing:
  - tx_push, tx_push_data and req_ready are combinational from state, grant and tx_full.
  - grant, busy and timeout_err are registered.
  - tx_push is never high while tx_full=1.
- IDLE:
  - tx_push=0 and req_ready=0.
  - If any req_valid is high, pick the first set bit searching from last+1 with wrap-around.
  - Latch the pick into grant, go to HDR.
  - req_valid is only sampled here for arbitration; no byte is consumed.
- HDR:
  - When tx_full=0: tx_push=1, tx_push_data=HDR_BASE+g, go to PAY, clear the timeout counter.
- PAY:
  - req_ready[g]=~tx_full; all other req_ready bits are 0.
  - On valid[g]&ready[g]: tx_push=1, tx_push_data=req_data[g], clear the counter.
  - If req_last[g] is also set, go to CR.
  - Counter increments only on cycles with valid[g]=0. Stalls caused by tx_full=1 do not count.
  - When the counter reaches TIMEOUT-1 with valid[g] still 0:
    - pulse timeout_err for one cycle (registered, visible the next cycle);
    - go to CR, so the packet is closed with a trailer;
    - any bytes the requester sends later belong to its next packet.
- CR: when tx_full=0, push 8'h0D and go to LF.
- LF:
  - When tx_full=0, push 8'h0A, set last=g, go to IDLE.
  - grant clears on entry to IDLE.
- Latency:
  - At least one IDLE cycle separates packets.
  - Minimum packet time is 1 IDLE + L+3 push cycles for L payload bytes.
- Zero-length packets are impossible: every packet carries at least one payload byte.
- Requesters that raise or drop req_valid while not granted are ignored. They must hold the byte until ready.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package uart_sched_pkg holds:
  - state enum: IDLE, HDR, PAY, CR, LF;
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - default HDR_BASE.
- One sub-module, rr_arbiter (N_REQ parameter):
  - inputs: req vector and last pointer;
  - outputs: one-hot gnt and index;
  - purely combinational.
- The FSM, timeout counter and output mux live in uart_tx_scheduler.

Test Plan:
- Single packet, single requester: req0 sends 0x31,0x32 (last on 0x32), tx_full=0 → pushes 0x41,0x31,0x32,0x0D,0x0A on consecutive push cycles; grant=01 throughout; busy falls the cycle after the LF push.
- Both requesting continuously, 1-byte packets → packet order A,B,A,B; headers alternate 0x41/0x42; the first grant after reset goes to req0.
- FIFO back-pressure: hold tx_full=1 for 20 cycles during PAY → tx_push=0 and req_ready=0 for those cycles; no timeout_err; the byte stream resumes intact.
- Timeout: TIMEOUT=16, req1 sends one byte then drops valid → timeout_err pulses once 16 cycles later; stream ends 0x42,b,0x0D,0x0A; req0 is then granted.
- Reset mid-PAY: assert reset=0 asynchronously → tx_push=0, grant=0, busy=0 immediately; after release, req0 wins arbitration.
- Backpressure in HDR/CR/LF: tx_full=1 for 3 cycles in each state → each byte is pushed exactly once, never duplicated or skipped.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared state encoding and framing constants for the UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        CR,
        LF
    } sched_state_t;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] DEFAULT_HDR_BASE = 8'h41;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', with wrap-around.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX FIFO push port between N_REQ byte streams, framing each
// packet as header, payload, CR, LF and aborting stalled requesters.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         N_REQ    = 2,
    parameter logic [7:0] HDR_BASE = DEFAULT_HDR_BASE,
    parameter int         TIMEOUT  = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               tx_full,
    output logic               tx_push,
    output logic [7:0]         tx_push_data,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int            IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

    sched_state_t     state, next_state;
    logic [IW-1:0]    gidx, last_ptr, arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic [CW-1:0]    cnt;
    logic             own_valid, own_last;
    logic [7:0]       own_data;
    logic             start_pkt, cnt_clear, cnt_inc, abort, pkt_done;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req  (req_valid),
        .last (last_ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign own_valid = req_valid[gidx];
    assign own_last  = req_last[gidx];
    assign own_data  = req_data[{gidx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Pushes only happen while the FIFO has room; a stall in PAY only ages the
    // packet when the owner itself has nothing to offer.
    always_comb begin
        next_state   = state;
        tx_push      = 1'b0;
        tx_push_data = 8'h00;
        req_ready    = '0;
        start_pkt    = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        abort        = 1'b0;
        pkt_done     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    start_pkt  = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = HDR_BASE + 8'(gidx);
                    cnt_clear    = 1'b1;
                    next_state   = PAY;
                end
            end
            PAY: begin
                req_ready[gidx] = ~tx_full;
                if (own_valid) begin
                    if (!tx_full) begin
                        tx_push      = 1'b1;
                        tx_push_data = own_data;
                        cnt_clear    = 1'b1;
                        if (own_last) next_state = CR;
                    end
                end else if (cnt >= CNT_LIMIT) begin
                    abort      = 1'b1;
                    next_state = CR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CR: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = ASCII_CR;
                    next_state   = LF;
                end
            end
            LF: begin
                if (!tx_full) begin
                    tx_push      = 1'b1;
                    tx_push_data = ASCII_LF;
                    pkt_done     = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            gidx        <= '0;
            last_ptr    <= LAST_INIT;
            cnt         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            busy        <= (next_state != IDLE);
            timeout_err <= abort;
            if (start_pkt) begin
                grant <= arb_gnt;
                gidx  <= arb_idx;
            end else if (pkt_done) begin
                grant    <= '0;
                last_ptr <= gidx;
            end
            if (cnt_clear || abort)          cnt <= '0;
            else if (cnt_inc && cnt != '1)   cnt <= cnt + CW'(1);
        end
    end

endmodule
